// File: rtl/multdiv_scheduler.sv
// rtl/multdiv_scheduler.sv - issue/stall/writeback scheduler for an external multdiv unit
// Optional MULTDIV_TIMEOUT_EN forces an exception after TIMEOUT_CYCLES busy cycles.
module multdiv_scheduler #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        control_mult_dx,
  input  logic        control_div_dx,
  input  logic        flush_dx,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  rd_dx,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        control_stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, WB = 2'd3} state_t;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic TimeoutEn = 1'b1;
`else
  localparam logic TimeoutEn = 1'b0;
`endif
  localparam logic [5:0] TimeoutLast = 6'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       opMult;
  logic [4:0] capRd;
  logic [5:0] busyCount;
  logic       start;
  logic       timeoutHit;
  logic       finishBusy;
  logic       wbExc;

  assign start      = (control_mult_dx | control_div_dx) & ~flush_dx;
  assign timeoutHit = TimeoutEn & (busyCount == TimeoutLast) & ~md_resultRDY;
  assign finishBusy = md_resultRDY | timeoutHit;
  // A timeout completion always reports an exception.
  assign wbExc      = md_resultRDY ? md_exception : 1'b1;

  // Gated by reset so the pipeline is released even while DX still requests an op.
  assign control_stall = reset &
                         (((state == IDLE) & start) |
                          (((state == ISSUE) | (state == BUSY)) & ~flush_dx));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      opMult       <= 1'b0;
      capRd        <= 5'd0;
      busyCount    <= 6'd0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      md_operandA  <= 32'd0;
      md_operandB  <= 32'd0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= 32'd0;
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= 32'd0;
      case (state)
        IDLE: begin
          if (start) begin
            opMult       <= control_mult_dx;
            capRd        <= rd_dx;
            md_operandA  <= data_operandA;
            md_operandB  <= data_operandB;
            md_ctrl_MULT <= control_mult_dx;
            md_ctrl_DIV  <= ~control_mult_dx;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          busyCount <= 6'd0;
          state     <= flush_dx ? IDLE : BUSY;
        end
        BUSY: begin
          if (busyCount != 6'd63) begin
            busyCount <= busyCount + 6'd1;
          end
          if (flush_dx) begin
            state <= IDLE;
          end else if (finishBusy) begin
            state    <= WB;
            wb_valid <= 1'b1;
            if (wbExc) begin
              wb_reg  <= 5'd30;
              wb_data <= opMult ? 32'd4 : 32'd5;
              wb_we   <= 1'b1;
            end else begin
              wb_reg  <= capRd;
              wb_data <= md_result;
              wb_we   <= (capRd != 5'd0);
            end
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// tb/tb_multdiv_scheduler.sv - self-checking bench for multdiv_scheduler
// Covers timeout behaviour for both MULTDIV_TIMEOUT_EN builds.
module tb_multdiv_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        control_mult_dx = 1'b0;
  logic        control_div_dx = 1'b0;
  logic        flush_dx = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [4:0]  rd_dx = 5'd0;
  logic        md_resultRDY = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = 32'd0;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        control_stall;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  multdiv_scheduler #(.TIMEOUT_CYCLES(40)) dut (
    .clock(clock), .reset(reset),
    .control_mult_dx(control_mult_dx), .control_div_dx(control_div_dx),
    .flush_dx(flush_dx), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .rd_dx(rd_dx), .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .md_result(md_result), .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB), .control_stall(control_stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        isMult;
    logic        isDiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          busy;
    logic        exc;
    logic [31:0] res;
    logic [4:0]  expReg;
    logic [31:0] expData;
    logic        expWe;
    logic        dxInWb;
  } vec_t;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic        w;
  } wb_t;

  wb_t  sb[$];
  wb_t  mon;
  vec_t vecs[7];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input logic m, input logic d, input int a, input int b,
                              input int rd, input int busy, input logic exc, input int res,
                              input int er, input int ed, input logic ew, input logic dx);
    vec_t v;
    v.isMult = m; v.isDiv = d; v.a = a; v.b = b; v.rd = 5'(rd);
    v.busy = busy; v.exc = exc; v.res = res;
    v.expReg = 5'(er); v.expData = ed; v.expWe = ew; v.dxInWb = dx;
    return v;
  endfunction

  // Scoreboard consumer: every wb_valid cycle must match the oldest pending record.
  initial forever begin
    @(negedge clock);
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: wb_valid=1 with no completion pending (wb_reg=%0d)", wb_reg);
      end else begin
        mon = sb.pop_front();
        chk("wb_reg", 32'(wb_reg), 32'(mon.r));
        chk("wb_data", wb_data, mon.d);
        chk("wb_we", 32'(wb_we), 32'(mon.w));
      end
    end
  end

  task automatic runOp(input vec_t v, input string nm);
    int stallN;
    stallN = 0;
    @(negedge clock);
    control_mult_dx = v.isMult; control_div_dx = v.isDiv;
    data_operandA = v.a; data_operandB = v.b; rd_dx = v.rd;
    sb.push_back('{v.expReg, v.expData, v.expWe});
    #1;
    chk({nm, "_stall_start"}, 32'(control_stall), 32'd1);
    if (control_stall) stallN++;
    @(negedge clock);
    control_mult_dx = 1'b0; control_div_dx = 1'b0;
    data_operandA = 32'hFFFF_FFFF; data_operandB = 32'hA5A5_A5A5; rd_dx = 5'd17;
    #1;
    if (control_stall) stallN++;
    chk({nm, "_issue_mult"}, 32'(md_ctrl_MULT), 32'(v.isMult));
    chk({nm, "_issue_div"}, 32'(md_ctrl_DIV), 32'(v.isDiv & ~v.isMult));
    chk({nm, "_issue_opA"}, md_operandA, v.a);
    for (int k = 1; k <= v.busy; k++) begin
      @(negedge clock);
      if (k == v.busy) begin
        md_resultRDY = 1'b1; md_result = v.res; md_exception = v.exc;
      end
      #1;
      if (control_stall) stallN++;
      if (k == 1) chk({nm, "_pulse_once"}, 32'(md_ctrl_MULT | md_ctrl_DIV), 32'd0);
    end
    @(negedge clock);
    md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'h1234_5678;
    if (v.dxInWb) control_mult_dx = 1'b1;
    #1;
    chk({nm, "_wb_valid"}, 32'(wb_valid), 32'd1);
    chk({nm, "_stall_wb"}, 32'(control_stall), 32'd0);
    chk({nm, "_opB_hold"}, md_operandB, v.b);
    chk({nm, "_stall_cycles"}, 32'(stallN), 32'(v.busy + 2));
    @(negedge clock);
    control_mult_dx = 1'b0;
    #1;
    chk({nm, "_after_wbv"}, 32'(wb_valid), 32'd0);
    chk({nm, "_after_data"}, wb_data, 32'd0);
    chk({nm, "_after_stall"}, 32'(control_stall), 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    //              mult div  A    B  rd busy exc res  eReg eData eWe dxInWb
    vecs[0] = mk(1'b1, 1'b0,   7,   6,  5, 32, 1'b0, 42,    5,  42, 1'b1, 1'b0);
    vecs[1] = mk(1'b0, 1'b1,  10,   0,  9,  4, 1'b1,  0,   30,   5, 1'b1, 1'b0);
    vecs[2] = mk(1'b1, 1'b0,   3,   4,  0,  2, 1'b0, 12,    0,  12, 1'b0, 1'b0);
    vecs[3] = mk(1'b1, 1'b0,   2,   9,  1,  1, 1'b0, 18,    1,  18, 1'b1, 1'b1);
    vecs[4] = mk(1'b1, 1'b1,   5,   4,  7,  3, 1'b1, 20,   30,   4, 1'b1, 1'b0);
    vecs[5] = mk(1'b0, 1'b1, 100,   7, 31,  6, 1'b0, 14,   31,  14, 1'b1, 1'b0);
    vecs[6] = mk(1'b1, 1'b0,   3,   3,  2,  5, 1'b0,  9,    2,   9, 1'b1, 1'b0);

    repeat (2) @(negedge clock);
    chk("reset_stall", 32'(control_stall), 32'd0);
    chk("reset_wbv", 32'(wb_valid), 32'd0);
    chk("reset_mult", 32'(md_ctrl_MULT | md_ctrl_DIV), 32'd0);
    chk("reset_opA", md_operandA, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) runOp(vecs[i], $sformatf("vec%0d", i));

    // Flush at the third BUSY cycle aborts the div with no writeback.
    @(negedge clock); control_div_dx = 1'b1; data_operandA = 32'd8; data_operandB = 32'd2; rd_dx = 5'd4;
    @(negedge clock); control_div_dx = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); flush_dx = 1'b1;
    #1; chk("flush_stall", 32'(control_stall), 32'd0);
    @(negedge clock); flush_dx = 1'b0;
    #1; chk("flush_idle_stall", 32'(control_stall), 32'd0);
    chk("flush_no_wb", 32'(wb_valid), 32'd0);
    md_resultRDY = 1'b1; md_result = 32'd5;
    @(negedge clock); md_resultRDY = 1'b0;
    #1; chk("flush_stray_rdy", 32'(wb_valid), 32'd0);
    runOp(vecs[6], "vec6");

    // Asynchronous reset in the middle of BUSY.
    @(negedge clock); control_mult_dx = 1'b1; data_operandA = 32'd1; data_operandB = 32'd2; rd_dx = 5'd3;
    @(negedge clock); control_mult_dx = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2; reset = 1'b0; control_mult_dx = 1'b1;
    #1;
    chk("arst_stall", 32'(control_stall), 32'd0);
    chk("arst_opA", md_operandA, 32'd0);
    chk("arst_opB", md_operandB, 32'd0);
    chk("arst_wbv", 32'(wb_valid), 32'd0);
    @(negedge clock); control_mult_dx = 1'b0; reset = 1'b1; md_resultRDY = 1'b1; md_result = 32'd77;
    @(negedge clock); md_resultRDY = 1'b0;
    #1; chk("arst_stray_wbv", 32'(wb_valid), 32'd0);
    chk("arst_stray_stall", 32'(control_stall), 32'd0);
    @(negedge clock);
    #1; chk("arst_stray_wbv2", 32'(wb_valid), 32'd0);

    // Unit never answers.
    n = 0; seen = 1'b0;
    @(negedge clock); control_mult_dx = 1'b1; data_operandA = 32'd6; data_operandB = 32'd6; rd_dx = 5'd8;
`ifdef MULTDIV_TIMEOUT_EN
    sb.push_back('{5'd30, 32'd4, 1'b1});
`endif
    for (int i = 0; i < 150; i++) begin
      #1;
      if (wb_valid) begin
        seen = 1'b1;
        break;
      end
      if (control_stall) n++;
      @(negedge clock); control_mult_dx = 1'b0;
    end
`ifdef MULTDIV_TIMEOUT_EN
    chk("tmo_seen", 32'(seen), 32'd1);
    chk("tmo_stall_cycles", 32'(n), 32'd42);
`else
    chk("notmo_no_wb", 32'(seen), 32'd0);
    chk("notmo_stall_cycles", 32'(n), 32'd150);
    @(negedge clock); flush_dx = 1'b1;
    @(negedge clock); flush_dx = 1'b0;
    #1; chk("notmo_abort_stall", 32'(control_stall), 32'd0);
`endif

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multdiv_scheduler.md
MULTDIV_SCHEDULER -- requirements
Module: multdiv_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40, BUSY cycles allowed before forced exception (range 2..63).
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port control_mult_dx  input  1  DX holds mult.
REQ-005 SHALL have port control_div_dx  input  1  DX holds div.
REQ-006 SHALL have port flush_dx  input  1  DX instruction squashed (taken branch/jump).
REQ-007 SHALL have ports data_operandA, data_operandB  input  32 each  DX operands (post-bypass).
REQ-008 SHALL have port rd_dx  input  5  DX destination register.
REQ-009 SHALL have ports md_resultRDY  input  1, md_exception  input  1, md_result  input  32  from multdiv unit.
REQ-010 SHALL have ports md_ctrl_MULT, md_ctrl_DIV  output  1 each  unit start pulses.
REQ-011 SHALL have ports md_operandA, md_operandB  output  32 each  registered operands to unit.
REQ-012 SHALL have port control_stall  output  1  freezes PC, FD, DX; bubbles XM.
REQ-013 SHALL have ports wb_valid  output  1, wb_we  output  1, wb_reg  output  5, wb_data  output  32  completion record.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, BUSY, WB.
REQ-015 SHALL define start = (control_mult_dx | control_div_dx) & ~flush_dx; both asserted SHALL be treated as mult.
REQ-016 IDLE: on start, capture operands, rd_dx, op (mult/div) into registers and go to ISSUE; else stay.
REQ-017 ISSUE: assert md_ctrl_MULT or md_ctrl_DIV (per captured op) for exactly this one cycle, clear cycle counter, go to BUSY.
REQ-018 BUSY: increment 6-bit counter each cycle; on md_resultRDY latch md_result and md_exception, go to WB.
REQ-019 control_stall SHALL be combinational: 1 when (IDLE & start) or ISSUE or BUSY; 0 in WB.
REQ-020 WB: wb_valid=1 for exactly one cycle, then IDLE; control_mult_dx/control_div_dx in WB SHALL be ignored (stale DX copy).
REQ-021 WB without exception: wb_reg=captured rd, wb_data=latched result, wb_we=1 unless rd=0 (then 0).
REQ-022 WB with exception: wb_reg=30, wb_data=4 (mult) or 5 (div), wb_we=1.
REQ-023 flush_dx in ISSUE or BUSY SHALL abort: go to IDLE next cycle, no wb_valid, control_stall=0 that cycle; start pulse already issued is not retracted.
REQ-024 md_resultRDY arriving in IDLE, ISSUE or WB SHALL be ignored.
REQ-025 md_operandA/B SHALL hold captured values stable from ISSUE through WB.
REQ-026 Outside WB, wb_valid, wb_we SHALL be 0 and wb_reg, wb_data SHALL be 0.
REQ-027 Minimum latency start-to-wb_valid SHALL be 3 cycles (IDLE->ISSUE->BUSY with RDY->WB).

Reset
REQ-028 Reset low SHALL immediately force IDLE, counter=0, all captured registers and outputs=0, control_stall=0 regardless of clock.
REQ-029 Reset deasserted mid-operation SHALL resume in IDLE with no pending result; first start thereafter behaves per REQ-016.

Configuration
REQ-030 Macro MULTDIV_TIMEOUT_EN defined: in BUSY, if counter reaches TIMEOUT_CYCLES-1 with md_resultRDY low, go to WB with exception forced (REQ-022 values).
REQ-031 Macro MULTDIV_TIMEOUT_EN undefined: no timeout; BUSY waits indefinitely for md_resultRDY; counter still increments, saturating at 63.

Verification
REQ-032 mult A=7,B=6,rd=5; unit RDY after 32 BUSY cycles, result=42 -> one-cycle md_ctrl_MULT, stall high 34 cycles, wb_valid with wb_reg=5, wb_data=42, wb_we=1.
REQ-033 div A=10,B=0,rd=9; RDY with md_exception=1 -> wb_reg=30, wb_data=5, wb_we=1.
REQ-034 mult rd=0, result=12 -> wb_valid=1, wb_we=0.
REQ-035 div issued, flush_dx at 3rd BUSY cycle -> IDLE next cycle, no wb_valid; subsequent mult A=3,B=3,rd=2 completes wb_data=9.
REQ-036 MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=40, RDY never asserted -> wb_valid at BUSY cycle 40 with wb_reg=30, wb_data=4 (mult); undefined build -> stall held 100+ cycles.
REQ-037 reset pulled low during BUSY -> outputs 0 asynchronously, state IDLE, stray RDY afterward ignored.
